fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register feeding `control_unit`. Owns the program counter, drives a synchronous-read instruction memory, and presents one 16-bit instruction per cycle on `if_id_instr`. Handles jump redirect, self-stalls while a beq/bne in IF/ID awaits resolution from EX, and generates the `branch_resolved` feedback that `control_unit` uses to drop `beq`/`bne` after one cycle.

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: owns the PC, drives a 1-cycle
// synchronous instruction memory, redirects on jumps and waits on branches.
module fetch_stage #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            branch_resolved
);

  typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, REFILL = 2'd2} state_t;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_JUMP, PC_BRANCH} pc_op_t;
  typedef enum logic [1:0] {IR_HOLD, IR_LOAD, IR_BUBBLE} ir_op_t;

  state_t          state, state_next;
  pc_op_t          pc_op;
  ir_op_t          ir_op;
  logic [PC_W-1:0] pc_q, rd_pc_q;
  logic            is_br;

  assign is_br = if_id_valid &&
                 ((if_id_instr[15:12] == 4'b1011) || (if_id_instr[15:12] == 4'b1100));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state <= REFILL;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (jump)       state_next = REFILL;
        else if (is_br) state_next = BR_WAIT;
      end
      BR_WAIT: begin
        if (br_valid) state_next = br_taken ? REFILL : RUN;
      end
      REFILL:  state_next = RUN;
      default: state_next = REFILL;
    endcase
  end

  always_comb begin
    pc_op   = PC_HOLD;
    ir_op   = IR_HOLD;
    imem_en = 1'b0;
    case (state)
      RUN: begin
        if (jump) begin
          pc_op = PC_JUMP;
          ir_op = IR_BUBBLE;
        end else if (!(is_br || stall)) begin
          pc_op   = PC_INC;
          ir_op   = IR_LOAD;
          imem_en = 1'b1;
        end
      end
      BR_WAIT: begin
        // The fall-through word has been parked on imem_rdata since entry.
        if (br_valid && br_taken) begin
          pc_op = PC_BRANCH;
          ir_op = IR_BUBBLE;
        end else if (br_valid) begin
          pc_op   = PC_INC;
          ir_op   = IR_LOAD;
          imem_en = 1'b1;
        end
      end
      REFILL: begin
        pc_op   = PC_INC;
        ir_op   = IR_BUBBLE;
        imem_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign branch_resolved = (state == BR_WAIT);
  assign imem_addr       = pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      rd_pc_q     <= '0;
      if_id_instr <= 16'h0000;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      case (pc_op)
        PC_INC:    pc_q <= pc_q + PC_W'(1);
        PC_JUMP:   pc_q <= if_id_instr[PC_W-1:0];
        PC_BRANCH: pc_q <= br_target;
        default:   ;
      endcase
      if (imem_en) rd_pc_q <= pc_q;
      case (ir_op)
        IR_LOAD: begin
          if_id_instr <= imem_rdata;
          if_id_pc    <= rd_pc_q;
          if_id_valid <= 1'b1;
        end
        IR_BUBBLE: begin
          if_id_instr <= 16'h0000;
          if_id_pc    <= '0;
          if_id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: per-cycle stimulus/expectation vectors are
// queued, then applied and compared one clock at a time.
module tb_fetch_stage;

  logic        clk;
  logic        reset, stall, jump, br_valid, br_taken;
  logic [7:0]  br_target, imem_addr, if_id_pc;
  logic        imem_en, if_id_valid, branch_resolved;
  logic [15:0] imem_rdata, if_id_instr;
  logic [15:0] mem [256];

  logic [3:0]  imem_addr4, if_id_pc4;
  logic        imem_en4, if_id_valid4, branch_resolved4;
  logic [15:0] imem_rdata4, if_id_instr4;
  logic [15:0] mem4 [16];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        stall;
    logic        brv;
    logic        brt;
    logic [7:0]  tgt;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        valid;
    logic        bres;
  } vec_t;

  vec_t q[$];

  fetch_stage #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .branch_resolved(branch_resolved)
  );

  fetch_stage #(.PC_W(4), .RESET_PC(4'h0)) dut4 (
    .clk(clk), .reset(reset), .stall(1'b0), .jump(1'b0),
    .br_valid(1'b0), .br_taken(1'b0), .br_target(4'h0),
    .imem_addr(imem_addr4), .imem_en(imem_en4), .imem_rdata(imem_rdata4),
    .if_id_instr(if_id_instr4), .if_id_pc(if_id_pc4), .if_id_valid(if_id_valid4),
    .branch_resolved(branch_resolved4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memories and a control_unit jump decode.
  always @(posedge clk) if (imem_en)  imem_rdata  <= mem[imem_addr];
  always @(posedge clk) if (imem_en4) imem_rdata4 <= mem4[imem_addr4];
  assign jump = if_id_valid && (if_id_instr[15:12] == 4'hD);

  function automatic vec_t vec(input logic s, input logic bv, input logic bt,
                               input logic [7:0] tg, input logic [15:0] ins,
                               input logic [7:0] p, input logic vl, input logic br);
    vec_t r;
    r.stall = s;  r.brv = bv;  r.brt = bt;  r.tgt = tg;
    r.instr = ins; r.pc = p;   r.valid = vl; r.bres = br;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int k = 0; k < 256; k++) mem[k] = 16'h2000 + 16'(k);
    for (int k = 0; k < 16; k++)  mem4[k] = 16'h2000 + 16'(k);
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Straight-line expectations after reset: one bubble, then words 0..n-1.
  task automatic push_prelude(input int n);
    q.push_back(vec(0, 0, 0, 8'h00, 16'h0000, 8'h00, 0, 0));
    for (int k = 0; k < n; k++)
      q.push_back(vec(0, 0, 0, 8'h00, 16'h2000 + 16'(k), 8'(k), 1, 0));
  endtask

  task automatic test_reset();
    fill_mem();
    do_reset();
    n_vec++; if (if_id_instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr: got %h want 0000", if_id_instr); end
    n_vec++; if (if_id_pc !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", if_id_pc); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    n_vec++; if (branch_resolved !== 1'b0) begin n_err++; $display("FAIL reset_bres: got %b want 0", branch_resolved); end
    n_vec++; if (imem_en !== 1'b1) begin n_err++; $display("FAIL reset_imem_en: got %b want 1", imem_en); end
    n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL reset_imem_addr: got %h want 00", imem_addr); end
  endtask

  task automatic test_straight();
    vec_t e;
    fill_mem();
    do_reset();
    push_prelude(6);
    while (q.size() > 0) begin
      e = q.pop_front();
      stall = e.stall; br_valid = e.brv; br_taken = e.brt; br_target = e.tgt;
      tick();
      n_vec++;
      if ({if_id_instr, if_id_valid, branch_resolved} !== {e.instr, e.valid, e.bres} || (e.valid && if_id_pc !== e.pc)) begin
        n_err++;
        $display("FAIL straight: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr, if_id_pc, if_id_valid, branch_resolved, e.instr, e.pc, e.valid, e.bres);
      end
    end
  endtask

  task automatic test_stall();
    vec_t e;
    fill_mem();
    do_reset();
    push_prelude(4);
    for (int i = 0; i < 3; i++) q.push_back(vec(1, 0, 0, 8'h00, 16'h2003, 8'h03, 1, 0));
    while (q.size() > 0) begin
      e = q.pop_front();
      stall = e.stall; br_valid = e.brv; br_taken = e.brt; br_target = e.tgt;
      tick();
      n_vec++;
      if ({if_id_instr, if_id_valid, branch_resolved} !== {e.instr, e.valid, e.bres} || (e.valid && if_id_pc !== e.pc)) begin
        n_err++;
        $display("FAIL stall_hold: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr, if_id_pc, if_id_valid, branch_resolved, e.instr, e.pc, e.valid, e.bres);
      end
    end
    n_vec++; if (imem_addr !== 8'h05) begin n_err++; $display("FAIL stall_pc: got %h want 05", imem_addr); end
    n_vec++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL stall_imem_en: got %b want 0", imem_en); end
    n_vec++; if (imem_rdata !== 16'h2004) begin n_err++; $display("FAIL stall_rdata: got %h want 2004", imem_rdata); end
    q.push_back(vec(0, 0, 0, 8'h00, 16'h2004, 8'h04, 1, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'h2005, 8'h05, 1, 0));
    while (q.size() > 0) begin
      e = q.pop_front();
      stall = e.stall; br_valid = e.brv; br_taken = e.brt; br_target = e.tgt;
      tick();
      n_vec++;
      if ({if_id_instr, if_id_valid, branch_resolved} !== {e.instr, e.valid, e.bres} || (e.valid && if_id_pc !== e.pc)) begin
        n_err++;
        $display("FAIL stall_release: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr, if_id_pc, if_id_valid, branch_resolved, e.instr, e.pc, e.valid, e.bres);
      end
    end
  endtask

  task automatic test_jump();
    vec_t e;
    fill_mem();
    mem[5] = 16'hD040;
    do_reset();
    push_prelude(5);
    q.push_back(vec(0, 0, 0, 8'h00, 16'hD040, 8'h05, 1, 0));
    q.push_back(vec(1, 0, 0, 8'h00, 16'h0000, 8'h00, 0, 0));
    q.push_back(vec(1, 0, 0, 8'h00, 16'h0000, 8'h00, 0, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'h2040, 8'h40, 1, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'h2041, 8'h41, 1, 0));
    while (q.size() > 0) begin
      e = q.pop_front();
      stall = e.stall; br_valid = e.brv; br_taken = e.brt; br_target = e.tgt;
      tick();
      n_vec++;
      if ({if_id_instr, if_id_valid, branch_resolved} !== {e.instr, e.valid, e.bres} || (e.valid && if_id_pc !== e.pc)) begin
        n_err++;
        $display("FAIL jump: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr, if_id_pc, if_id_valid, branch_resolved, e.instr, e.pc, e.valid, e.bres);
      end
    end
  endtask

  task automatic test_branch_taken();
    vec_t e;
    fill_mem();
    mem[8] = 16'hB000;
    do_reset();
    push_prelude(8);
    q.push_back(vec(0, 0, 0, 8'h00, 16'hB000, 8'h08, 1, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'hB000, 8'h08, 1, 1));
    q.push_back(vec(1, 0, 0, 8'h00, 16'hB000, 8'h08, 1, 1));
    q.push_back(vec(0, 0, 0, 8'h00, 16'hB000, 8'h08, 1, 1));
    q.push_back(vec(1, 1, 1, 8'h20, 16'h0000, 8'h00, 0, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'h0000, 8'h00, 0, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'h2020, 8'h20, 1, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'h2021, 8'h21, 1, 0));
    while (q.size() > 0) begin
      e = q.pop_front();
      stall = e.stall; br_valid = e.brv; br_taken = e.brt; br_target = e.tgt;
      tick();
      n_vec++;
      if ({if_id_instr, if_id_valid, branch_resolved} !== {e.instr, e.valid, e.bres} || (e.valid && if_id_pc !== e.pc)) begin
        n_err++;
        $display("FAIL br_taken: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr, if_id_pc, if_id_valid, branch_resolved, e.instr, e.pc, e.valid, e.bres);
      end
    end
  endtask

  task automatic test_branch_not_taken();
    vec_t e;
    fill_mem();
    mem[8] = 16'hC000;
    do_reset();
    push_prelude(8);
    q.push_back(vec(0, 0, 0, 8'h00, 16'hC000, 8'h08, 1, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'hC000, 8'h08, 1, 1));
    q.push_back(vec(0, 1, 0, 8'h55, 16'h2009, 8'h09, 1, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'h200A, 8'h0A, 1, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'h200B, 8'h0B, 1, 0));
    while (q.size() > 0) begin
      e = q.pop_front();
      stall = e.stall; br_valid = e.brv; br_taken = e.brt; br_target = e.tgt;
      tick();
      n_vec++;
      if ({if_id_instr, if_id_valid, branch_resolved} !== {e.instr, e.valid, e.bres} || (e.valid && if_id_pc !== e.pc)) begin
        n_err++;
        $display("FAIL br_not_taken: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr, if_id_pc, if_id_valid, branch_resolved, e.instr, e.pc, e.valid, e.bres);
      end
    end
  endtask

  task automatic test_reset_mid_brwait();
    vec_t e;
    fill_mem();
    mem[8] = 16'hB000;
    do_reset();
    push_prelude(8);
    q.push_back(vec(0, 0, 0, 8'h00, 16'hB000, 8'h08, 1, 0));
    q.push_back(vec(0, 0, 0, 8'h00, 16'hB000, 8'h08, 1, 1));
    while (q.size() > 0) begin
      e = q.pop_front();
      stall = e.stall; br_valid = e.brv; br_taken = e.brt; br_target = e.tgt;
      tick();
      n_vec++;
      if ({if_id_instr, if_id_valid, branch_resolved} !== {e.instr, e.valid, e.bres} || (e.valid && if_id_pc !== e.pc)) begin
        n_err++;
        $display("FAIL rst_brwait_pre: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr, if_id_pc, if_id_valid, branch_resolved, e.instr, e.pc, e.valid, e.bres);
      end
    end
    reset = 1'b0; br_valid = 1'b1; br_taken = 1'b1; br_target = 8'h20;
    tick();
    reset = 1'b1; br_valid = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    n_vec++; if (branch_resolved !== 1'b0) begin n_err++; $display("FAIL rst_brwait_bres: got %b want 0", branch_resolved); end
    n_vec++; if ({if_id_instr, if_id_valid} !== 17'h0) begin n_err++; $display("FAIL rst_brwait_ifid: got %h v%b want 0000 v0", if_id_instr, if_id_valid); end
    n_vec++; if ({imem_en, imem_addr} !== 9'h100) begin n_err++; $display("FAIL rst_brwait_fetch: got en%b addr %h want en1 addr 00", imem_en, imem_addr); end
    push_prelude(2);
    while (q.size() > 0) begin
      e = q.pop_front();
      stall = e.stall; br_valid = e.brv; br_taken = e.brt; br_target = e.tgt;
      tick();
      n_vec++;
      if ({if_id_instr, if_id_valid, branch_resolved} !== {e.instr, e.valid, e.bres} || (e.valid && if_id_pc !== e.pc)) begin
        n_err++;
        $display("FAIL rst_brwait_refill: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr, if_id_pc, if_id_valid, branch_resolved, e.instr, e.pc, e.valid, e.bres);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t e;
    fill_mem();
    do_reset();
    q.push_back(vec(0, 0, 0, 8'h00, 16'h0000, 8'h00, 0, 0));
    for (int k = 0; k < 19; k++)
      q.push_back(vec(0, 0, 0, 8'h00, 16'h2000 + 16'(k % 16), 8'(k % 16), 1, 0));
    while (q.size() > 0) begin
      e = q.pop_front();
      tick();
      n_vec++;
      if ({if_id_instr4, if_id_valid4, branch_resolved4} !== {e.instr, e.valid, e.bres} || (e.valid && {4'h0, if_id_pc4} !== e.pc)) begin
        n_err++;
        $display("FAIL wrap4: got %h@%h v%b br%b, want %h@%h v%b br%b",
                 if_id_instr4, if_id_pc4, if_id_valid4, branch_resolved4, e.instr, e.pc, e.valid, e.bres);
      end
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    test_reset();
    test_straight();
    test_stall();
    test_jump();
    test_branch_taken();
    test_branch_not_taken();
    test_reset_mid_brwait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
